// File: rtl/dma_pkg.sv
// dma_pkg: shared register indices, control/status bit positions and FSM state type
// Revision: 1.0
`default_nettype none

package dma_pkg;

  localparam logic [1:0] REG_SRC = 2'd0;
  localparam logic [1:0] REG_DST = 2'd1;
  localparam logic [1:0] REG_CNT = 2'd2;
  localparam logic [1:0] REG_CTL = 2'd3;

  localparam int BIT_START = 0;
  localparam int BIT_BUSY  = 0;
  localparam int BIT_IEN   = 1;
  localparam int BIT_DONE  = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/dma.sv
// dma: single-channel word-copy engine; register responder plus bus initiator
// Revision: 1.0
`default_nettype none

module dma
  import dma_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stb,
  input  logic        we,
  input  logic [1:0]  addr,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        ack,
  output logic        irq,
  output logic        mst_stb,
  output logic        mst_we,
  output logic [29:0] mst_addr,
  output logic [31:0] mst_dout,
  input  logic [31:0] mst_din,
  input  logic        mst_ack
);

  state_e             state_q, state_d;
  logic [29:0]        src_q, src_d;
  logic [29:0]        dst_q, dst_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        latch_q, latch_d;
  logic               ien_q, ien_d;
  logic               done_q, done_d;
  logic               irq_q;
  logic               mst_stb_q, mst_stb_d;
  logic               mst_we_q, mst_we_d;
  logic [29:0]        mst_addr_q, mst_addr_d;
  logic [31:0]        mst_dout_q, mst_dout_d;

  logic               busy;
  logic               reg_wr;

  assign busy   = (state_q != IDLE);
  assign reg_wr = stb & we;
  assign ack    = stb;

  always_comb begin
    data_out = 32'h0;
    unique case (addr)
      REG_SRC: data_out = {src_q, 2'b00};
      REG_DST: data_out = {dst_q, 2'b00};
      REG_CNT: data_out = {{(32-CNT_W){1'b0}}, cnt_q};
      default: data_out = {29'h0, done_q, ien_q, busy};
    endcase
  end

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    cnt_d   = cnt_q;
    latch_d = latch_q;
    ien_d   = ien_q;
    done_d  = done_q;

    if (reg_wr && !busy) begin
      unique case (addr)
        REG_SRC: src_d = data_in[31:2];
        REG_DST: dst_d = data_in[31:2];
        REG_CNT: cnt_d = data_in[CNT_W-1:0];
        default: ;
      endcase
    end

    if (reg_wr && addr == REG_CTL) begin
      ien_d = data_in[BIT_IEN];
      if (!data_in[BIT_DONE]) done_d = 1'b0;
      if (data_in[BIT_START] && !busy) begin
        if (cnt_q == '0) begin
          done_d = 1'b1;
        end else begin
          state_d = RD;
          done_d  = 1'b0;
        end
      end
    end

    // Completion is evaluated after the CTRL write so a same-edge done set wins over a clear.
    unique case (state_q)
      RD: begin
        if (mst_ack) begin
          latch_d = mst_din;
          state_d = WR;
        end
      end
      WR: begin
        if (mst_ack) begin
          src_d = src_q + 30'd1;
          dst_d = dst_q + 30'd1;
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = RD;
          end
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    mst_stb_d  = (state_d != IDLE);
    mst_we_d   = (state_d == WR);
    mst_addr_d = mst_addr_q;
    mst_dout_d = mst_dout_q;
    unique case (state_d)
      RD: mst_addr_d = src_d;
      WR: begin
        mst_addr_d = dst_d;
        mst_dout_d = latch_d;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      src_q      <= '0;
      dst_q      <= '0;
      cnt_q      <= '0;
      latch_q    <= '0;
      ien_q      <= 1'b0;
      done_q     <= 1'b0;
      irq_q      <= 1'b0;
      mst_stb_q  <= 1'b0;
      mst_we_q   <= 1'b0;
      mst_addr_q <= '0;
      mst_dout_q <= '0;
    end else begin
      state_q    <= state_d;
      src_q      <= src_d;
      dst_q      <= dst_d;
      cnt_q      <= cnt_d;
      latch_q    <= latch_d;
      ien_q      <= ien_d;
      done_q     <= done_d;
      irq_q      <= done_q & ien_q;
      mst_stb_q  <= mst_stb_d;
      mst_we_q   <= mst_we_d;
      mst_addr_q <= mst_addr_d;
      mst_dout_q <= mst_dout_d;
    end
  end

  assign irq      = irq_q;
  assign mst_stb  = mst_stb_q;
  assign mst_we   = mst_we_q;
  assign mst_addr = mst_addr_q;
  assign mst_dout = mst_dout_q;

endmodule

`default_nettype wire
